// File: rtl/bm_piso_tx.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over a valid/ready
// handshake and shifts it out one bit per clock with a qualifying dout_valid.
module bm_piso_tx #(
    parameter int WIDTH     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pdata,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             last_bit;
    logic             accept;

    always_comb begin
        last_bit   = (state == SHIFT) && (cnt == LAST);
        load_ready = rst_n && ((state == IDLE) || last_bit);
        accept     = load_valid && load_ready;
        cnt_nxt    = cnt + 1'b1;
        if (MSB_FIRST) begin
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // The head bit of the shift register is the serial output; the register
    // is all-zero in IDLE, so dout idles low without extra gating.
    assign dout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (accept) begin
            // Covers both a fresh start from IDLE and a zero-gap reload on the last bit.
            state      <= SHIFT;
            shreg      <= pdata;
            cnt        <= '0;
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else if (state == SHIFT) begin
            if (last_bit) begin
                state      <= IDLE;
                shreg      <= '0;
                cnt        <= '0;
                dout_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                shreg <= shreg_shifted;
                cnt   <= cnt_nxt;
                // done is registered one cycle early so it lines up with the last bit.
                done  <= (cnt_nxt == LAST);
            end
        end
    end

endmodule
